// File: rtl/river_pkg.sv
// Shared types and constants for the river-crossing puzzle engine.
//  status_e     : game status encoding (PLAY/WON/LOST)
//  WSC_EAT_MASK : predator/prey matrix of the classic wolf/sheep/cabbage puzzle
//  ITEM_*       : item indices of the classic puzzle
package river_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WON  = 2'd1,
    LOST = 2'd2
  } status_e;

  localparam int unsigned ITEM_CAB   = 0;
  localparam int unsigned ITEM_SHEEP = 1;
  localparam int unsigned ITEM_WOLF  = 2;

  // bit[i*3+j] set -> item i eats item j: wolf eats sheep, sheep eats cabbage
  localparam logic [8:0] WSC_EAT_MASK = 9'h088;

endpackage

// File: rtl/river_if.sv
// Move/observation bus of the river-crossing engine.
//  master : request side (solver/bench) drives restart, move_valid, move_sel, undo
//  slave  : engine side drives move_ready, state, status, error, done, reject, move_cnt
interface river_if
  import river_pkg::*;
#(
  parameter int unsigned N_ITEMS = 3,
  parameter int unsigned CNT_W   = 8
);

  logic               restart;
  logic               move_valid;
  logic               move_ready;
  logic [N_ITEMS-1:0] move_sel;
  logic               undo;
  logic [N_ITEMS:0]   state;
  status_e            status;
  logic               error;
  logic               done;
  logic               reject;
  logic [CNT_W-1:0]   move_cnt;

  modport master (
    output restart, move_valid, move_sel, undo,
    input  move_ready, state, status, error, done, reject, move_cnt
  );

  modport slave (
    input  restart, move_valid, move_sel, undo,
    output move_ready, state, status, error, done, reject, move_cnt
  );

endinterface

// File: rtl/river_crossing_ctrl_move_history.sv
// Circular LIFO of accepted moves; a push when full overwrites the oldest entry.
//  clk, rst  : clock, async active-low reset
//  clear_i   : drop all entries
//  push_i    : store data_i as newest entry
//  pop_i     : remove newest entry (ignored when empty)
//  data_i    : move selection to store
//  top_c_o   : newest entry (combinational, valid when not empty)
//  empty_c_o : no entries stored (combinational)
module move_history #(
  parameter int unsigned N_ITEMS    = 3,
  parameter int unsigned HIST_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [N_ITEMS-1:0] data_i,
  output logic [N_ITEMS-1:0] top_c_o,
  output logic               empty_c_o
);

  localparam int unsigned PTR_W  = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int unsigned FILL_W = $clog2(HIST_DEPTH + 1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(HIST_DEPTH - 1);
  localparam logic [FILL_W-1:0] FULL     = FILL_W'(HIST_DEPTH);

  logic [N_ITEMS-1:0] mem_q [HIST_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [FILL_W-1:0]  fill_q;
  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W-1:0]   prev_ptr;

  // wr_ptr_q points at the slot the next push writes; newest entry sits just below it
  assign next_ptr  = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
  assign prev_ptr  = (wr_ptr_q == '0) ? LAST_PTR : wr_ptr_q - PTR_W'(1);
  assign top_c_o   = mem_q[prev_ptr];
  assign empty_c_o = (fill_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      for (int k = 0; k < int'(HIST_DEPTH); k++) mem_q[k] <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q        <= next_ptr;
      if (fill_q != FULL) fill_q <= fill_q + FILL_W'(1);
    end else if (pop_i && !empty_c_o) begin
      wr_ptr_q <= prev_ptr;
      fill_q   <= fill_q - FILL_W'(1);
    end
  end

endmodule

// File: rtl/river_crossing_ctrl.sv
// River-crossing puzzle engine: accepts moves, rejects illegal ones, detects win/loss, supports undo.
//  clk, rst : clock, async active-low reset
//  bus      : river_if slave port (restart/move/undo requests in, state/status/flags/counter out)
module river_crossing_ctrl
  import river_pkg::*;
#(
  parameter int unsigned                  N_ITEMS    = 3,
  parameter int unsigned                  CAPACITY   = 1,
  parameter logic [N_ITEMS*N_ITEMS-1:0]   EAT_MASK   = (N_ITEMS*N_ITEMS)'(WSC_EAT_MASK),
  parameter int unsigned                  HIST_DEPTH = 8,
  parameter int unsigned                  CNT_W      = 8
) (
  input logic     clk,
  input logic     rst,
  river_if.slave  bus
);

  logic [N_ITEMS:0]   state_q, state_d;
  status_e            status_q, status_d;
  logic               error_q, error_d;
  logic               done_q, done_d;
  logic               reject_q, reject_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               hist_clear, hist_push, hist_pop;
  logic [N_ITEMS-1:0] hist_top;
  logic               hist_empty;
  logic               handshake;
  logic               legal;

  function automatic int unsigned popcount(input logic [N_ITEMS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(N_ITEMS); i++) n += int'(v[i]);
    return n;
  endfunction

  // Any predator left alone with its prey on the bank the farmer is not on
  function automatic logic is_lost(input logic [N_ITEMS:0] s);
    logic lost;
    lost = 1'b0;
    for (int i = 0; i < int'(N_ITEMS); i++) begin
      for (int j = 0; j < int'(N_ITEMS); j++) begin
        if (i != j && EAT_MASK[i*int'(N_ITEMS)+j] &&
            s[i] == s[j] && s[i] != s[N_ITEMS]) lost = 1'b1;
      end
    end
    return lost;
  endfunction

  // Every carried item must share the farmer's bank
  function automatic logic items_with_farmer(input logic [N_ITEMS:0] s,
                                             input logic [N_ITEMS-1:0] sel);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(N_ITEMS); i++) begin
      if (sel[i] && s[i] != s[N_ITEMS]) ok = 1'b0;
    end
    return ok;
  endfunction

  assign bus.move_ready = (status_q == PLAY) && !bus.undo && !bus.restart;
  assign handshake      = bus.move_valid && bus.move_ready;
  assign legal          = (popcount(bus.move_sel) <= CAPACITY) &&
                          items_with_farmer(state_q, bus.move_sel);

  move_history #(
    .N_ITEMS    (N_ITEMS),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (hist_clear),
    .push_i    (hist_push),
    .pop_i     (hist_pop),
    .data_i    (bus.move_sel),
    .top_c_o   (hist_top),
    .empty_c_o (hist_empty)
  );

  // Next-state: restart > undo > move; status always derived from the next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    reject_d   = 1'b0;
    hist_clear = 1'b0;
    hist_push  = 1'b0;
    hist_pop   = 1'b0;

    if (bus.restart) begin
      state_d    = '0;
      cnt_d      = '0;
      hist_clear = 1'b1;
    end else if (bus.undo) begin
      if (hist_empty) begin
        reject_d = 1'b1;
      end else begin
        hist_pop = 1'b1;
        state_d  = state_q ^ {1'b1, hist_top};
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (handshake) begin
      if (legal) begin
        hist_push = 1'b1;
        state_d   = state_q ^ {1'b1, bus.move_sel};
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        reject_d = 1'b1;
      end
    end

    if (is_lost(state_d))   status_d = LOST;
    else if (&state_d)      status_d = WON;
    else                    status_d = PLAY;

    error_d = (status_d == LOST);
    done_d  = (status_d == WON);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= '0;
      status_q <= PLAY;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      error_q  <= error_d;
      done_q   <= done_d;
      reject_q <= reject_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.status   = status_q;
  assign bus.error    = error_q;
  assign bus.done     = done_q;
  assign bus.reject   = reject_q;
  assign bus.move_cnt = cnt_q;

endmodule

// File: tb/tb_river_crossing_ctrl.sv
// Directed bench for river_crossing_ctrl: default engine plus a HIST_DEPTH=4 engine for history wrap.
module tb_river_crossing_ctrl;
  import river_pkg::*;

  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;

  river_if #(.N_ITEMS(3), .CNT_W(8)) bus_a ();
  river_if #(.N_ITEMS(3), .CNT_W(8)) bus_b ();

  river_crossing_ctrl #(
    .N_ITEMS(3), .CAPACITY(1), .EAT_MASK(9'h088), .HIST_DEPTH(8), .CNT_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  river_crossing_ctrl #(
    .N_ITEMS(3), .CAPACITY(1), .EAT_MASK(9'h088), .HIST_DEPTH(4), .CNT_W(8)
  ) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.restart    = 1'b0;
    bus_a.move_valid = 1'b0;
    bus_a.move_sel   = 3'b000;
    bus_a.undo       = 1'b0;
  endtask

  task automatic mv(input logic [2:0] sel);
    bus_a.move_valid = 1'b1;
    bus_a.move_sel   = sel;
    tick();
    idle_a();
  endtask

  task automatic undo_a();
    bus_a.undo = 1'b1;
    tick();
    idle_a();
  endtask

  logic [2:0] win_seq [7];

  initial begin
    n_err = 0;
    n_chk = 0;
    win_seq = '{3'b010, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b010};
    rst = 1'b0;
    idle_a();
    bus_b.restart = 1'b0; bus_b.move_valid = 1'b0; bus_b.move_sel = 3'b000; bus_b.undo = 1'b0;
    #12;
    chk("rst_state",  32'(bus_a.state), 32'h0);
    chk("rst_status", 32'(bus_a.status), 32'(PLAY));
    chk("rst_cnt",    32'(bus_a.move_cnt), 32'h0);
    chk("rst_reject", 32'(bus_a.reject), 32'h0);
    chk("rst_ready",  32'(bus_a.move_ready), 32'h1);
    rst = 1'b1;
    tick();

    // 1: classic winning sequence
    for (int k = 0; k < 7; k++) begin
      mv(win_seq[k]);
      chk("t1_noreject", 32'(bus_a.reject), 32'h0);
    end
    chk("t1_state",  32'(bus_a.state), 32'hF);
    chk("t1_status", 32'(bus_a.status), 32'(WON));
    chk("t1_done",   32'(bus_a.done), 32'h1);
    chk("t1_cnt",    32'(bus_a.move_cnt), 32'd7);
    chk("t1_ready",  32'(bus_a.move_ready), 32'h0);
    // WON holds while further moves are presented
    mv(3'b000);
    chk("t1_hold",   32'(bus_a.state), 32'hF);
    bus_a.restart = 1'b1; tick(); idle_a();
    chk("t1_rst_state", 32'(bus_a.state), 32'h0);
    chk("t1_rst_done",  32'(bus_a.done), 32'h0);

    // 2: wolf first loses, undo recovers
    mv(3'b100);
    chk("t2_state",  32'(bus_a.state), 32'hC);
    chk("t2_status", 32'(bus_a.status), 32'(LOST));
    chk("t2_error",  32'(bus_a.error), 32'h1);
    chk("t2_ready",  32'(bus_a.move_ready), 32'h0);
    undo_a();
    chk("t2_u_state",  32'(bus_a.state), 32'h0);
    chk("t2_u_status", 32'(bus_a.status), 32'(PLAY));
    chk("t2_u_error",  32'(bus_a.error), 32'h0);
    chk("t2_u_cnt",    32'(bus_a.move_cnt), 32'h0);

    // 3: over-capacity and wrong-bank moves rejected
    mv(3'b011);
    chk("t3_cap_rej",   32'(bus_a.reject), 32'h1);
    chk("t3_cap_state", 32'(bus_a.state), 32'h0);
    tick();
    chk("t3_rej_pulse", 32'(bus_a.reject), 32'h0);
    mv(3'b010);
    chk("t3_state1", 32'(bus_a.state), 32'hA);
    mv(3'b001);
    chk("t3_bank_rej",   32'(bus_a.reject), 32'h1);
    chk("t3_bank_state", 32'(bus_a.state), 32'hA);
    chk("t3_bank_cnt",   32'(bus_a.move_cnt), 32'h1);
    bus_a.restart = 1'b1; tick(); idle_a();

    // 4: undo on empty history, undo beats a simultaneous move
    undo_a();
    chk("t4_rej",   32'(bus_a.reject), 32'h1);
    chk("t4_state", 32'(bus_a.state), 32'h0);
    chk("t4_cnt",   32'(bus_a.move_cnt), 32'h0);
    tick();
    chk("t4_rej_off", 32'(bus_a.reject), 32'h0);
    mv(3'b010);
    bus_a.undo = 1'b1; bus_a.move_valid = 1'b1; bus_a.move_sel = 3'b000;
    #1;
    chk("t4_ready_undo", 32'(bus_a.move_ready), 32'h0);
    tick(); idle_a();
    chk("t4_both_state",  32'(bus_a.state), 32'h0);
    chk("t4_both_cnt",    32'(bus_a.move_cnt), 32'h0);
    chk("t4_both_reject", 32'(bus_a.reject), 32'h0);

    // 5: depth-4 history wraps; only 4 undos succeed
    for (int k = 0; k < 6; k++) begin
      bus_b.move_valid = 1'b1; bus_b.move_sel = 3'b010;
      tick();
      bus_b.move_valid = 1'b0;
    end
    chk("t5_cnt6",  32'(bus_b.move_cnt), 32'd6);
    chk("t5_state", 32'(bus_b.state), 32'h0);
    for (int k = 0; k < 4; k++) begin
      bus_b.undo = 1'b1; tick(); bus_b.undo = 1'b0;
      chk("t5_undo_ok", 32'(bus_b.reject), 32'h0);
    end
    chk("t5_cnt2", 32'(bus_b.move_cnt), 32'd2);
    bus_b.undo = 1'b1; tick(); bus_b.undo = 1'b0;
    chk("t5_undo5_rej", 32'(bus_b.reject), 32'h1);
    chk("t5_cnt_hold",  32'(bus_b.move_cnt), 32'd2);
    chk("t5_state_end", 32'(bus_b.state), 32'h0);

    // 6: async reset mid-game, then restart out of WON
    bus_a.restart = 1'b1; tick(); idle_a();
    for (int k = 0; k < 6; k++) mv(win_seq[k]);
    chk("t6_mid_state", 32'(bus_a.state), 32'h5);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_ar_state",  32'(bus_a.state), 32'h0);
    chk("t6_ar_status", 32'(bus_a.status), 32'(PLAY));
    chk("t6_ar_cnt",    32'(bus_a.move_cnt), 32'h0);
    chk("t6_ar_error",  32'(bus_a.error), 32'h0);
    chk("t6_ar_done",   32'(bus_a.done), 32'h0);
    #2;
    rst = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) mv(win_seq[k]);
    chk("t6_won", 32'(bus_a.status), 32'(WON));
    bus_a.restart = 1'b1; bus_a.move_valid = 1'b1; bus_a.move_sel = 3'b000;
    tick(); idle_a();
    chk("t6_rs_state",  32'(bus_a.state), 32'h0);
    chk("t6_rs_status", 32'(bus_a.status), 32'(PLAY));
    chk("t6_rs_cnt",    32'(bus_a.move_cnt), 32'h0);
    chk("t6_rs_reject", 32'(bus_a.reject), 32'h0);
    undo_a();
    chk("t6_rs_hist_empty", 32'(bus_a.reject), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
